mem_bus_arbiter: RTL

- Shares the single memory bus between the instruction-fetch requester (I) and the data load/store requester (D).
- Registers the granted request onto the bus and holds it stable until the bus acknowledges.
- Returns a one-cycle response pulse to the owning requester, and times out hung transactions with an error response.
- Sits between the ifu/memu stage units and the external memory interface.

---
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Memory bus arbiter port bundle: fetch and data requesters plus the bus.
// slave is the arbiter's view; master is the requester/bus-side view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_ok;
  logic              iresp_err;
  logic [DATA_W-1:0] iresp_data;

  logic                dreq_valid;
  logic                dreq_we;
  logic [ADDR_W-1:0]   dreq_addr;
  logic [2:0]          dreq_size;
  logic [DATA_W-1:0]   dreq_wdata;
  logic [DATA_W/8-1:0] dreq_strobe;
  logic                dresp_ok;
  logic                dresp_err;
  logic [DATA_W-1:0]   dresp_data;

  logic                breq_valid;
  logic                breq_we;
  logic [ADDR_W-1:0]   breq_addr;
  logic [2:0]          breq_size;
  logic [DATA_W-1:0]   breq_wdata;
  logic [DATA_W/8-1:0] breq_strobe;
  logic                bus_ok;
  logic [DATA_W-1:0]   bus_rdata;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_ok, iresp_err, iresp_data,
    input  dreq_valid, dreq_we, dreq_addr,
    input  dreq_size, dreq_wdata, dreq_strobe,
    output dresp_ok, dresp_err, dresp_data,
    output breq_valid, breq_we, breq_addr,
    output breq_size, breq_wdata, breq_strobe,
    input  bus_ok, bus_rdata
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_ok, iresp_err, iresp_data,
    output dreq_valid, dreq_we, dreq_addr,
    output dreq_size, dreq_wdata, dreq_strobe,
    input  dresp_ok, dresp_err, dresp_data,
    input  breq_valid, breq_we, breq_addr,
    input  breq_size, breq_wdata, breq_strobe,
    output bus_ok, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between fetch (I) and load/store (D).
// Registered grant held until bus_ok or timeout, then a 1-cycle response.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bif
);
  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, GNT_I, GNT_D, RESP_I, RESP_D
  } state_t;

  state_t state, nxt;

  logic              last_d;
  logic              pick_i;
  logic              pick_d;
  logic              in_gnt;
  logic              tmo_hit;
  logic              r_i;
  logic              r_d;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // a tie goes to whichever side did not win last
  assign pick_d = bif.dreq_valid &&
                  (!bif.ireq_valid || !last_d);
  assign pick_i = bif.ireq_valid && !pick_d;

  assign in_gnt  = (state == GNT_I) ||
                   (state == GNT_D);
  assign tmo_hit = (TIMEOUT != 0) &&
                   (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_d:  nxt = GNT_D;
          pick_i:  nxt = GNT_I;
          default: nxt = IDLE;
        endcase
      end
      GNT_I:
        if (bif.bus_ok || tmo_hit) nxt = RESP_I;
      GNT_D:
        if (bif.bus_ok || tmo_hit) nxt = RESP_D;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d  <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && pick_d) begin
      last_d  <= 1'b1;
      cnt     <= '0;
      we_q    <= bif.dreq_we;
      addr_q  <= bif.dreq_addr;
      size_q  <= bif.dreq_size;
      wdata_q <= bif.dreq_wdata;
      strb_q  <= bif.dreq_strobe;
    end else if (state == IDLE && pick_i) begin
      last_d  <= 1'b0;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= bif.ireq_addr;
      size_q  <= 3'b011;
      wdata_q <= '0;
      strb_q  <= '1;
    end else if (in_gnt) begin
      // bus_ok beats a timeout landing in the same cycle
      if (bif.bus_ok) begin
        rdata_q <= we_q ? '0 : bif.bus_rdata;
        err_q   <= 1'b0;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign r_i = (state == RESP_I);
  assign r_d = (state == RESP_D);

  assign bif.breq_valid  = in_gnt;
  assign bif.breq_we     = we_q;
  assign bif.breq_addr   = addr_q;
  assign bif.breq_size   = size_q;
  assign bif.breq_wdata  = wdata_q;
  assign bif.breq_strobe = strb_q;

  assign bif.iresp_ok   = r_i;
  assign bif.iresp_err  = r_i && err_q;
  assign bif.iresp_data = r_i ? rdata_q : '0;
  assign bif.dresp_ok   = r_d;
  assign bif.dresp_err  = r_d && err_q;
  assign bif.dresp_data = r_d ? rdata_q : '0;
endmodule
